conv3x3_filter: RTL and testbench

Downstream consumer of the 3-line pixel buffer. Each cycle it takes one vertical column of three RGB565 pixels plus the matching hcount/vcount/valid. It assembles a 3x3 window, applies a selectable 3x3 kernel per colour channel, clamps the result, and emits one filtered RGB565 pixel with delayed timing signals. The output feeds the downstream pixel consumers (thresholding and display path).

---
 rtl/conv3x3_filter.sv | 93 +++++++++
 tb/tb_conv3x3_filter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 RGB565 convolution over streamed pixel columns with selectable kernel.
// Three pipeline stages: window assembly, per-channel MAC, shift/clamp/pack.
module conv3x3_filter #(
   parameter int DEFAULT_KERNEL = 1,
   parameter int HCOUNT_W = 11,
   parameter int VCOUNT_W = 10
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [2:0][15:0]    line_buffer_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                data_valid_in,
   input  logic [1:0]          kernel_select_in,
   output logic [15:0]         pixel_out,
   output logic [HCOUNT_W-1:0] hcount_out,
   output logic [VCOUNT_W-1:0] vcount_out,
   output logic                data_valid_out
);
   logic [2:0][2:0][15:0] win;
   logic [1:0] kern, kern2;
   logic v1, v2;
   logic [HCOUNT_W-1:0] hc1, hc2;
   logic [VCOUNT_W-1:0] vc1, vc2;
   logic signed [11:0] sr, sg, sb, nr, ng, nb;

   function automatic logic signed [11:0] coef(input logic [1:0] k, input int r, input int c);
      logic ce, ed;
      ce = (r == 1) && (c == 1);
      ed = (r == 1) != (c == 1);
      return k == 2'd0 ? (ce ? 12'sd1 : 12'sd0) :
             k == 2'd1 ? (ce ? 12'sd4 : ed ? 12'sd2 : 12'sd1) :
             k == 2'd2 ? (ce ? 12'sd5 : ed ? -12'sd1 : 12'sd0) :
                         (ce ? 12'sd8 : -12'sd1);
   endfunction

   function automatic logic signed [11:0] post(input logic signed [11:0] s, input logic [1:0] k);
      return k == 2'd1 ? s >>> 4 : s;
   endfunction

   function automatic logic [4:0] clamp5(input logic signed [11:0] v);
      return v < 12'sd0 ? 5'd0 : v > 12'sd31 ? 5'd31 : v[4:0];
   endfunction

   function automatic logic [5:0] clamp6(input logic signed [11:0] v);
      return v < 12'sd0 ? 6'd0 : v > 12'sd63 ? 6'd63 : v[5:0];
   endfunction

   // win[c][r]: c0 oldest column, row 0 top; |sum| <= 1008 so 12 bits never overflow
   always_comb begin
      nr = '0;
      ng = '0;
      nb = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            nr = nr + coef(kern, r, c) * $signed({7'd0, win[c][r][15:11]});
            ng = ng + coef(kern, r, c) * $signed({6'd0, win[c][r][10:5]});
            nb = nb + coef(kern, r, c) * $signed({7'd0, win[c][r][4:0]});
         end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         win <= '0;
         kern <= 2'(DEFAULT_KERNEL);
         kern2 <= '0;
         {v1, v2, data_valid_out} <= '0;
         {hc1, hc2, hcount_out} <= '0;
         {vc1, vc2, vcount_out} <= '0;
         {sr, sg, sb} <= '0;
         pixel_out <= '0;
      end else begin
         if (data_valid_in) begin
            win <= hcount_in == '0 ? {3{line_buffer_in}} : {line_buffer_in, win[2:1]};
            if (hcount_in == '0 && vcount_in == '0) kern <= kernel_select_in;
         end
         v1 <= data_valid_in;
         hc1 <= hcount_in;
         vc1 <= vcount_in;
         v2 <= v1;
         hc2 <= hc1;
         vc2 <= vc1;
         kern2 <= kern;
         sr <= nr;
         sg <= ng;
         sb <= nb;
         data_valid_out <= v2;
         hcount_out <= hc2;
         vcount_out <= vc2;
         if (v2) pixel_out <= {clamp5(post(sr, kern2)), clamp6(post(sg, kern2)), clamp5(post(sb, kern2))};
      end
   end
endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: directed frames with random data against a column-history convolution model.
module tb_conv3x3_filter;
   typedef logic [2:0][15:0] col_t;

   localparam int KK[4][9] = '{
      '{0, 0, 0, 0, 1, 0, 0, 0, 0},
      '{1, 2, 1, 2, 4, 2, 1, 2, 1},
      '{0, -1, 0, -1, 5, -1, 0, -1, 0},
      '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};

   logic clk_in = 0;
   logic rst_in = 1;
   col_t line_buffer_in = '0;
   logic [10:0] hcount_in = '0;
   logic [9:0] vcount_in = '0;
   logic data_valid_in = 0;
   logic [1:0] kernel_select_in = '0;
   logic [15:0] pixel_out;
   logic [10:0] hcount_out;
   logic [9:0] vcount_out;
   logic data_valid_out;

   int total = 0, bad = 0, n = 2, mk = 1;
   int ev[8192], eh[8192], evc[8192], ep[8192];
   logic [15:0] held = '0;
   col_t hist[$];

   conv3x3_filter dut (
      .clk_in(clk_in), .rst_in(rst_in), .line_buffer_in(line_buffer_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
      .kernel_select_in(kernel_select_in), .pixel_out(pixel_out),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .data_valid_out(data_valid_out));

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // cols[0] is the leftmost column of the 3x3 neighbourhood, cols[c][0] the top row
   function automatic logic [15:0] model_pix(input int k, input col_t cols[$]);
      int sh[3] = '{11, 5, 0};
      int mx[3] = '{31, 63, 31};
      logic [15:0] res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         int s = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               s += KK[k][r*3+c] * int'((cols[c][r] >> sh[ch]) & mx[ch]);
         if (k == 1) s = s >>> 4;
         s = s < 0 ? 0 : s > mx[ch] ? mx[ch] : s;
         res |= 16'(s << sh[ch]);
      end
      return res;
   endfunction

   task automatic step(input bit r, input bit v, input int h, input int vc, input col_t col, input int ks);
      rst_in = r;
      data_valid_in = v;
      hcount_in = 11'(h);
      vcount_in = 10'(vc);
      line_buffer_in = col;
      kernel_select_in = 2'(ks);
      if (r) begin
         mk = 1;
         hist = {col_t'(0), col_t'(0), col_t'(0)};
         held = '0;
         for (int i = n - 2; i <= n; i++) begin
            ev[i] = 0; eh[i] = 0; evc[i] = 0; ep[i] = 0;
         end
      end else begin
         if (v) begin
            if (h == 0 && vc == 0) mk = ks;
            if (h == 0) hist = {col, col, col};
            else begin
               hist.push_back(col);
               void'(hist.pop_front());
            end
            held = model_pix(mk, hist);
         end
         ev[n] = v; eh[n] = h; evc[n] = vc; ep[n] = held;
      end
      @(posedge clk_in);
      #1;
      chk("valid", 32'(data_valid_out), ev[n-2]);
      chk("hcount", 32'(hcount_out), eh[n-2]);
      chk("vcount", 32'(vcount_out), evc[n-2]);
      chk("pixel", 32'(pixel_out), ep[n-2]);
      n++;
   endtask

   task automatic frame(input int w, input int hgt, input int mode, input int k0, input int k1, input int rst_at);
      int idx = 0;
      for (int r = 0; r < hgt; r++)
         for (int c = 0; c < w; c++) begin
            col_t col;
            logic [15:0] px;
            bit v;
            px = {8'(r), 8'(c)};
            col = mode == 0 ? {3{16'h007B}} :
                  mode == 1 ? {px, px, px} :
                  mode == 2 ? {16'($urandom), 16'($urandom), 16'($urandom)} :
                  mode == 3 ? (c == 2 ? {16'h0, 16'hFFFF, 16'h0} : col_t'(0)) :
                  mode == 4 ? (c == 2 ? {16'hFFFF, 16'h0, 16'hFFFF} : {3{16'hFFFF}}) :
                              {3{16'd555}};
            v = mode == 5 ? 1'b0 : (mode == 2 && !(r == 0 && c == 0)) ? ($urandom % 4 != 0) : 1'b1;
            step(idx == rst_at, v, c, r, col, idx < w * hgt / 2 ? k0 : k1);
            idx++;
         end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, k1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         ev[i] = 0; eh[i] = 0; evc[i] = 0; ep[i] = 0;
      end
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 0);
      frame(16, 4, 0, 1, 1, -1);
      chk("flat_gauss", 32'(pixel_out), 32'h007B);
      frame(16, 4, 0, 3, 3, -1);
      chk("flat_lap", 32'(pixel_out), 32'h0000);
      frame(16, 4, 0, 2, 2, -1);
      chk("flat_sharp", 32'(pixel_out), 32'h007B);
      frame(4, 10, 5, 0, 0, -1);
      chk("invalid_hold", 32'(pixel_out), 32'h007B);
      frame(8, 3, 3, 2, 2, -1);
      frame(8, 3, 4, 3, 3, -1);
      chk("lap_neg", 32'(pixel_out), 32'h0000);
      frame(4, 10, 1, 0, 0, -1);
      frame(8, 4, 1, 0, 3, -1);
      frame(8, 4, 1, 3, 3, -1);
      frame(8, 4, 2, 2, 2, 13);
      for (int i = 0; i < 6; i++) frame(12, 5, 2, int'($urandom % 4), int'($urandom % 4), -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
